// File: rtl/noise_gen_mc_pkg.sv
// Shared constants, FSM encoding and LFSR helpers for the multi-channel noise generator.
package noise_gen_mc_pkg;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] SEED_SPREAD  = 32'h9E37_79B9;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // One right-shifting Galois step; the taps fold back in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Per-channel seed spread; an all-zero state would lock the LFSR, so map it to 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned ch);
    logic [31:0] v;
    v = base ^ (ch * SEED_SPREAD);
    return (v == '0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/noise_gen_mc_lfsr.sv
// 32-bit Galois LFSR with synchronous load; load wins over step.
module galois_lfsr
  import noise_gen_mc_pkg::*;
#(
  parameter logic [31:0] RST_SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  // LFSR state register: reset seed, reseed, or advance one step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  state <= RST_SEED;
    else if (load) state <= seed;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/noise_gen_mc.sv
// Multi-channel noise generator: rate divider, IDLE/ACCUM/OUT control and
// per-channel uniform or sum-of-ACC_N approximate Gaussian samples.
module noise_gen_mc
  import noise_gen_mc_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ACC_N  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [CNT_W-1:0]        i_rate_div,
  input  logic                    i_mode,
  input  logic [1:0]              i_gain_sh,
  input  logic                    i_seed_load,
  input  logic [31:0]             i_seed,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [NUM_CH*WIDTH-1:0] o_noise
);

  localparam int ACC_LG = $clog2(ACC_N);
  localparam int AW     = WIDTH + ACC_LG;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_LG-1:0] beat;
  logic [1:0]        gain_q;
  logic              tick, accept, step, last_beat;

  // A reduced divisor below the current count fires at once rather than wrapping.
  assign tick      = i_en && (cnt >= i_rate_div);
  assign last_beat = (beat == ACC_LG'(ACC_N - 1));
  assign o_valid   = (state_q == ST_OUT);

  // Next state, tick acceptance and LFSR step enable; reseed overrides everything.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = tick;
        if (tick) state_d = i_mode ? ST_ACCUM : ST_OUT;
      end
      ST_ACCUM: if (last_beat) state_d = ST_OUT;
      ST_OUT: if (i_ready) begin
        accept  = tick;
        state_d = tick ? (i_mode ? ST_ACCUM : ST_OUT) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_seed_load) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
    end
    step = (accept && !i_mode) || (state_q == ST_ACCUM && !i_seed_load);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Rate counter, accumulate beat count and gain captured at acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      beat   <= '0;
      gain_q <= '0;
    end else if (i_seed_load) begin
      cnt  <= '0;
      beat <= '0;
    end else if (accept) begin
      cnt    <= '0;
      beat   <= '0;
      gain_q <= i_gain_sh;
    end else begin
      // An unaccepted tick parks the counter until the output drains.
      if (i_en && !tick)        cnt  <= cnt + 1'b1;
      if (state_q == ST_ACCUM)  beat <= beat + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]              lfsr, nxt;
    logic signed [WIDTH-1:0]  samp;
    logic signed [AW-1:0]     sum, sum_sh;
    logic [AW-1:0]            acc_r;
    logic [WIDTH-1:0]         noise_r, uni_val;
    logic                     unused_nxt;

    galois_lfsr #(.RST_SEED(chan_seed(DEFAULT_SEED, c))) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .step    (step),
      .load    (i_seed_load),
      .seed    (chan_seed(i_seed, c)),
      .state   (lfsr)
    );

    // Samples come from the post-step state, so the value leaving matches the new LFSR state.
    assign nxt        = lfsr_next(lfsr);
    assign samp       = nxt[31 -: WIDTH];
    assign unused_nxt = ^nxt;
    assign sum        = acc_r + {{ACC_LG{samp[WIDTH-1]}}, samp};
    assign sum_sh     = sum >>> (ACC_LG + int'(gain_q));
    assign uni_val    = samp >>> i_gain_sh;
    assign o_noise[c*WIDTH +: WIDTH] = noise_r;

    // Accumulator and output sample register for this channel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        acc_r   <= '0;
        noise_r <= '0;
      end else if (i_seed_load) begin
        acc_r <= '0;
      end else if (accept) begin
        acc_r <= '0;
        if (!i_mode) noise_r <= uni_val;
      end else if (state_q == ST_ACCUM) begin
        acc_r <= sum;
        if (last_beat) noise_r <= sum_sh[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_noise_gen_mc.sv
// Randomized self-checking bench for noise_gen_mc against a transaction-level model.
module tb_noise_gen_mc;
  localparam int WIDTH = 24, NUM_CH = 4, CNT_W = 16, ACC_N = 4;

  logic                    i_clk = 1'b0, i_rst_n = 1'b1, i_en = 1'b0, i_mode = 1'b0;
  logic                    i_seed_load = 1'b0, i_ready = 1'b1;
  logic [CNT_W-1:0]        i_rate_div = '0;
  logic [1:0]              i_gain_sh = '0;
  logic [31:0]             i_seed = '0;
  logic                    o_valid;
  logic [NUM_CH*WIDTH-1:0] o_noise;

  int checks = 0, failures = 0;
  logic [31:0]      m_lfsr[NUM_CH];
  logic [WIDTH-1:0] exp_last[NUM_CH];
  logic             prev_valid = 1'b0, prev_xfer = 1'b0, cur_mode = 1'b0;
  int               cur_gain = 0;

  noise_gen_mc #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ACC_N(ACC_N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_rate_div(i_rate_div),
    .i_mode(i_mode), .i_gain_sh(i_gain_sh), .i_seed_load(i_seed_load), .i_seed(i_seed),
    .i_ready(i_ready), .o_valid(o_valid), .o_noise(o_noise)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference LFSR: shift right, fold taps in when a one drops out.
  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [31:0] m_seed(input logic [31:0] base, input int c);
    logic [31:0] v;
    v = base ^ (32'h9E37_79B9 * c);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  task automatic m_reseed(input logic [31:0] base);
    for (int c = 0; c < NUM_CH; c++) m_lfsr[c] = m_seed(base, c);
  endtask

  // Next expected sample of channel c: one draw (uniform) or floor-mean of ACC_N draws.
  task automatic m_next(input int c, output logic [WIDTH-1:0] e);
    longint acc;
    int     n, sh, v;
    acc = 0;
    n   = cur_mode ? ACC_N : 1;
    sh  = cur_gain + (cur_mode ? $clog2(ACC_N) : 0);
    for (int k = 0; k < n; k++) begin
      m_lfsr[c] = m_step(m_lfsr[c]);
      v = $signed(m_lfsr[c][31:32-WIDTH]);
      acc += v;
    end
    acc = acc >>> sh;
    e = acc[WIDTH-1:0];
  endtask

  // Advance one clock, then check any newly presented sample.
  task automatic cyc();
    logic [WIDTH-1:0] e;
    int v;
    prev_valid = o_valid;
    prev_xfer  = o_valid && i_ready;
    @(negedge i_clk);
    if (o_valid && (!prev_valid || prev_xfer)) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_next(c, e);
        exp_last[c] = e;
        chk($sformatf("noise_ch%0d", c), o_noise[c*WIDTH +: WIDTH], e);
        if (cur_gain == 3) begin
          v = $signed(o_noise[c*WIDTH +: WIDTH]);
          chk("gain3_range", (v >= -(1 << 20)) && (v < (1 << 20)), 1);
        end
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !o_valid; i++) cyc();
    chk({"wait_", tag}, o_valid, 1);
  endtask

  task automatic gap(input string tag, input int exp);
    int n;
    n = 0;
    do begin cyc(); n++; end while (!o_valid && n < 40);
    chk(tag, n, exp);
  endtask

  task automatic setup(input logic mode, input int gain, input int rd, input logic [31:0] seed);
    i_mode = mode; i_gain_sh = gain[1:0]; i_rate_div = rd[CNT_W-1:0];
    i_seed = seed; i_seed_load = 1'b1; i_en = 1'b1; i_ready = 1'b1;
    cur_mode = mode; cur_gain = gain;
    m_reseed(seed);
    cyc();
    i_seed_load = 1'b0;
  endtask

  initial begin
    m_reseed(32'hACE1_0001);
    #1 i_rst_n = 1'b0;
    #10;
    chk("rst_valid", o_valid, 0);
    chk("rst_noise", o_noise, 0);
    chk("rst_lfsr0", dut.g_ch[0].u_lfsr.state, m_lfsr[0]);
    chk("rst_lfsr3", dut.g_ch[3].u_lfsr.state, m_lfsr[3]);
    chk("rst_state", dut.state_q, noise_gen_mc_pkg::ST_IDLE);

    // Uniform, divisor 0: first sample one enabled clock after release, then continuous.
    @(negedge i_clk);
    i_rst_n = 1'b1; i_en = 1'b1; i_rate_div = '0; i_mode = 1'b0; i_ready = 1'b1;
    cur_gain = int'($urandom_range(0, 3)); i_gain_sh = cur_gain[1:0];
    cyc();
    chk("first_tick", o_valid, 1);
    for (int i = 0; i < 30; i++) begin cyc(); chk("cont_valid", o_valid, 1); end

    // Uniform, divisor 3: period 4; shrinking the divisor at count 2 fires next edge.
    setup(1'b0, int'($urandom_range(0, 3)), 3, $urandom);
    wait_valid("div3");
    for (int i = 0; i < 3; i++) gap("period4", 4);
    cyc(); cyc();
    chk("cnt_at2", dut.cnt, 2);
    i_rate_div = 16'd1;
    cyc();
    chk("fast_tick", o_valid, 1);

    // Gaussian, divisor 0: one sample every ACC_N+1 clocks, then random back-pressure.
    setup(1'b1, int'($urandom_range(0, 3)), 0, $urandom);
    wait_valid("gauss");
    for (int i = 0; i < 3; i++) gap("period5", ACC_N + 1);
    for (int i = 0; i < 40; i++) begin i_ready = 1'($urandom_range(0, 1)); cyc(); end
    i_ready = 1'b1;

    // Back-pressure hold in OUT for 10 clocks, then exactly one transfer.
    setup(1'b0, int'($urandom_range(0, 3)), 3, $urandom);
    wait_valid("hold");
    i_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_valid", o_valid, 1);
      for (int c = 0; c < NUM_CH; c++) chk("hold_noise", o_noise[c*WIDTH +: WIDTH], exp_last[c]);
    end
    chk("hold_cnt", dut.cnt, 3);
    chk("hold_lfsr0", dut.g_ch[0].u_lfsr.state, m_lfsr[0]);
    i_ready = 1'b1;
    cyc();
    chk("release_valid", o_valid, 1);
    cyc();
    chk("one_xfer", o_valid, 0);

    // Reseed with zero in the middle of an accumulation.
    setup(1'b1, 0, 0, $urandom);
    wait_valid("seed");
    cyc(); cyc();
    chk("in_accum", dut.state_q, noise_gen_mc_pkg::ST_ACCUM);
    i_seed = 32'd0; i_seed_load = 1'b1;
    m_reseed(32'd0);
    cyc();
    i_seed_load = 1'b0;
    chk("seed_valid", o_valid, 0);
    chk("seed_state", dut.state_q, noise_gen_mc_pkg::ST_IDLE);
    chk("seed_lfsr0", dut.g_ch[0].u_lfsr.state, 32'd1);
    chk("seed_lfsr1", dut.g_ch[1].u_lfsr.state, 32'h9E37_79B9);
    for (int i = 0; i < 12; i++) cyc();

    // Dropping enable mid-accumulation still completes the sample, then nothing more.
    wait_valid("en0");
    cyc();
    i_en = 1'b0;
    gap("en0_complete", ACC_N);
    cyc(); cyc();
    chk("en0_freeze", o_valid, 0);

    // Maximum attenuation with random divisor and back-pressure, both modes.
    for (int m = 0; m < 2; m++) begin
      setup(1'(m), 3, int'($urandom_range(0, 2)), $urandom);
      for (int i = 0; i < 50; i++) begin i_ready = 1'($urandom_range(0, 1)); cyc(); end
    end

    // Asynchronous reset while holding a sample in OUT.
    setup(1'b0, 1, 0, $urandom);
    wait_valid("arst");
    i_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_noise", o_noise, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_ready = 1'b1;
    m_reseed(32'hACE1_0001);
    cyc();
    chk("arst_first", o_valid, 1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
